feature_streamer: RTL and testbench
===================================

Name: feature_streamer

Overview:
Frame-to-stream source that drives the conv block's feature input. On a start pulse it reads one IMG_H x IMG_W frame of 8-bit pixels from a synchronous-read frame RAM in raster order. It presents the pixels on a valid/ready stream that connects directly to conv's i_feature_valid / i_feature / o_ready_feature / o_last_feature. It owns RAM read pacing, backpressure buffering and end-of-frame marking.

Parameters:
IMG_W, 32, pixels per row
IMG_H, 32, rows per frame
DATA_W, 8, pixel width (matches conv i_feature)
ADDR_W, $clog2(IMG_W*IMG_H), frame RAM address width (localparam-derived, not overridable)

Ports:
i_clk  in  1  clock; all logic on posedge
i_rst  in  1  synchronous, active-high reset
i_start  in  1  one-cycle frame start request
o_busy  out  1  high from accepted start until final pixel transfers
o_done  out  1  one-cycle pulse, cycle after final pixel transfer
o_rd_en  out  1  frame RAM read enable (combinational)
o_rd_addr  out  ADDR_W  frame RAM read address, raster index row*IMG_W+col
i_rd_data  in  DATA_W  RAM data, valid exactly 1 cycle after o_rd_en
o_feature_valid  out  1  stream valid -> conv i_feature_valid
o_feature  out  DATA_W  stream pixel -> conv i_feature
i_ready  in  1  stream ready <- conv o_ready_feature
o_last_feature  out  1  high with valid on final pixel (index IMG_W*IMG_H-1)

Behaviour:
- Clock i_clk. Reset i_rst is synchronous and active-high. All outputs are 0 in reset and in the cycle after reset.
- Transfer occurs on a posedge where o_feature_valid && i_ready.
- Once valid is high, o_feature and o_last_feature hold stable until transfer. Valid never drops without a transfer, except on reset.
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE: i_start=1 -> STREAM; clear read address and transfer counter; o_busy=1 from the next cycle.
  - STREAM: issue reads until address IMG_W*IMG_H-1 has been issued -> DRAIN.
  - DRAIN: wait for the final pixel transfer -> IDLE; o_done=1 for the next cycle only; o_busy falls the same cycle.
- i_start while busy is ignored. No queuing.
- Output buffer: 2-entry FIFO of {pixel, last}; o_feature/o_feature_valid come from its head register.
- Read credit:
  - o_rd_en = (state==STREAM) && (occupancy + inflight - pop) < 2, where inflight is a 1-bit register (read issued last cycle) and pop = transfer this cycle.
  - Returned data is pushed on the posedge after o_rd_en.
- Guarantees:
  - Never more than 2 pixels buffered or in flight.
  - Sustained 1 pixel/cycle while i_ready=1.
  - Zero pixel loss or duplication under any i_ready pattern.
- Latency: start sampled at edge 0 -> o_rd_en/addr 0 in cycle 1 -> first o_feature_valid in cycle 3. With i_ready=1 throughout, final transfer occurs at edge 2+IMG_W*IMG_H.
- Address/counter wrap: o_rd_addr increments by 1 per issued read and never exceeds IMG_W*IMG_H-1. o_last_feature is tagged by the read-side counter at push time.
- Simultaneous push and pop with occupancy 2: illegal by credit rule. Assert in simulation.
- Simultaneous push and pop with occupancy 1: head is replaced by the newly pushed entry; occupancy stays 1.
- Reset mid-frame: FIFO, inflight, counters and FSM cleared. Any i_rd_data returning after reset is discarded.
- Back-to-back frames: i_start in the same cycle as o_done is accepted.

Decomposition:
- Package feature_stream_pkg holds: pixel_t (logic [DATA_W-1:0]); typedef struct {pixel_t data; logic last;} stream_beat_t; state enum stream_state_e {IDLE, STREAM, DRAIN}; localparam FRAME_PIXELS = IMG_W*IMG_H.
- One natural sub-module: stream_skid_fifo (2-entry, stream_beat_t, push/pop/occupancy).

Test Plan:
- RAM model returns data = addr[7:0]; i_start pulse, i_ready=1 -> 1024 transfers with values 0..255 repeating; o_last_feature only on beat 1023; first valid in cycle 3; o_done pulse at edge 1027; o_busy high cycles 1..1026.
- Same, i_ready = 1 cycle high, 2 cycles low (repeating) -> exact sequence 0..255 repeating, no gaps or duplicates; o_feature stable while valid && !ready; no more than 2 reads issued ahead of transfers.
- i_ready=0 for 50 cycles after start -> exactly 2 reads issued (addr 0, 1); o_feature=0 held; release -> stream resumes at 1, 2, ...
- i_start pulsed at beat 500 mid-frame -> ignored: frame count 1024 unchanged, single o_done.
- i_rst asserted at beat 300 for 1 cycle -> all outputs 0 next cycle; new i_start -> stream restarts at address 0 with correct last/done.
- i_start held high during the o_done cycle -> second frame starts with no extra idle beyond the 3-cycle fill; 2048 total transfers; 2 last flags; 2 o_done pulses.

Source files
------------

// File: rtl/feature_stream_pkg.sv
// Shared types for the frame-RAM to feature-stream source feeding conv.
package feature_stream_pkg;

  localparam int PIXEL_W      = 8;
  localparam int DEF_IMG_W    = 32;
  localparam int DEF_IMG_H    = 32;
  localparam int FRAME_PIXELS = DEF_IMG_W * DEF_IMG_H;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef struct packed {
    pixel_t data;
    logic   last;
  } stream_beat_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } stream_state_e;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry beat buffer; the head register drives the outgoing stream directly.
module stream_skid_fifo
  import feature_stream_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  stream_beat_t push_beat,
  input  logic         pop,
  output stream_beat_t head,
  output logic         head_valid,
  output logic [1:0]   occupancy
);

  stream_beat_t head_q;
  stream_beat_t tail_q;
  logic [1:0]   occ_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case (occ_q)
        2'd0: begin
          if (push) begin
            head_q <= push_beat;
            occ_q  <= 2'd1;
          end
        end
        2'd1: begin
          // Push with pop while holding one entry replaces the head in place.
          if (push && pop) begin
            head_q <= push_beat;
          end else if (push) begin
            tail_q <= push_beat;
            occ_q  <= 2'd2;
          end else if (pop) begin
            occ_q <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_q <= tail_q;
            occ_q  <= 2'd1;
          end
        end
        default: occ_q <= 2'd0;
      endcase
    end
  end

  assign head       = head_q;
  assign head_valid = (occ_q != 2'd0);
  assign occupancy  = occ_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && occ_q == 2'd2));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(pop && occ_q == 2'd0));

endmodule

// File: rtl/feature_streamer.sv
// Reads one IMG_H x IMG_W frame from a sync-read RAM in raster order and
// streams it to conv with credit-limited prefetch and end-of-frame marking.
module feature_streamer
  import feature_stream_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int DATA_W = PIXEL_W,
  localparam int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_feature_valid,
  output logic [DATA_W-1:0] o_feature,
  input  logic              i_ready,
  output logic              o_last_feature,
  output logic [1:0]        o_dbg_state
);

  localparam int FRAME_LEN = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_STREAM = STREAM;
  localparam logic [1:0] ST_DRAIN  = DRAIN;

  logic [1:0]        state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] push_cnt_q;
  logic              inflight_q;
  logic              done_q;

  stream_beat_t push_beat;
  stream_beat_t head;
  logic         head_valid;
  logic [1:0]   occupancy;
  logic         pop;
  logic         rd_en;
  logic         last_read;
  logic [2:0]   committed;

  // Stream handshake: a beat transfers on any posedge with valid && ready;
  // once valid rises, data and last hold until that transfer, and valid only
  // drops after a transfer (or on reset).
  assign pop = head_valid && i_ready;

  // Entries buffered plus the read in flight, net of the beat leaving now.
  assign committed = {1'b0, occupancy} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en     = !i_rst && (state_q == ST_STREAM) && (committed < 3'd2);
  assign last_read = rd_en && (rd_addr_q == LAST_IDX);

  assign push_beat.data = pixel_t'(i_rd_data);
  assign push_beat.last = (push_cnt_q == LAST_IDX);

  stream_skid_fifo u_fifo (
    .clk        (i_clk),
    .rst        (i_rst),
    .push       (inflight_q),
    .push_beat  (push_beat),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .occupancy  (occupancy)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      rd_addr_q  <= '0;
      push_cnt_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      done_q     <= 1'b0;
      if (inflight_q) push_cnt_q <= push_cnt_q + 1'b1;
      if (rd_en && !last_read) rd_addr_q <= rd_addr_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q    <= ST_STREAM;
            rd_addr_q  <= '0;
            push_cnt_q <= '0;
          end
        end
        ST_STREAM: begin
          if (last_read) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop && head.last) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy          = (state_q != ST_IDLE);
  assign o_done          = done_q;
  assign o_rd_en         = rd_en;
  assign o_rd_addr       = rd_addr_q;
  assign o_feature_valid = head_valid;
  assign o_feature       = DATA_W'(head.data);
  assign o_last_feature  = head_valid && head.last;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_feature_streamer.sv
// Self-checking bench for feature_streamer: RAM model returns addr[7:0], a
// scoreboard holds the expected raster sequence of {last, pixel} beats.
module tb_feature_streamer;

  localparam int FRAME = 1024;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [9:0] rd_addr;
  logic [7:0] rd_data = 8'd0;
  logic       fvalid;
  logic [7:0] feature;
  logic       ready;
  logic       flast;
  logic [1:0] dbg_state;

  feature_streamer dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .o_busy          (busy),
    .o_done          (done),
    .o_rd_en         (rd_en),
    .o_rd_addr       (rd_addr),
    .i_rd_data       (rd_data),
    .o_feature_valid (fvalid),
    .o_feature       (feature),
    .i_ready         (ready),
    .o_last_feature  (flast),
    .o_dbg_state     (dbg_state)
  );

  // Synchronous-read frame RAM: data = address low byte, one cycle later.
  always @(posedge clk) begin
    if (rd_en === 1'b1) rd_data <= rd_addr[7:0];
  end

  // Scoreboard state
  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  int done_cyc_q[$];
  logic [8:0] exp_beat;
  logic [8:0] prev_beat;
  logic prev_hold = 1'b0;
  logic mon_en = 1'b0;
  int rd_exp = 0;
  int reads_issued = 0;
  int xfers = 0;
  int lasts = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_hold) begin
        checks++;
        if (fvalid !== 1'b1 || feature !== prev_beat[7:0] || flast !== prev_beat[8]) begin
          failures++;
          $display("FAIL hold_stable cyc=%0d got valid=%b data=%0d last=%b want valid=1 data=%0d last=%b",
                   cyc, fvalid, feature, flast, prev_beat[7:0], prev_beat[8]);
        end
      end
      if (rd_en === 1'b1) begin
        checks++;
        if (rd_addr !== 10'(rd_exp)) begin
          failures++;
          $display("FAIL rd_addr cyc=%0d got=%0d want=%0d", cyc, rd_addr, rd_exp);
        end
        rd_exp = (rd_exp + 1) % FRAME;
        reads_issued++;
      end
      if (fvalid === 1'b1 && ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_beat cyc=%0d got data=%0d last=%b want no beat", cyc, feature, flast);
        end else begin
          exp_beat = exp_q.pop_front();
          if ({flast, feature} !== exp_beat) begin
            failures++;
            $display("FAIL beat cyc=%0d got data=%0d last=%b want data=%0d last=%b",
                     cyc, feature, flast, exp_beat[7:0], exp_beat[8]);
          end
        end
        xfers++;
        if (flast === 1'b1) lasts++;
      end
      checks++;
      if (reads_issued - xfers > 2 || reads_issued - xfers < 0) begin
        failures++;
        $display("FAIL credit cyc=%0d got outstanding=%0d want 0..2", cyc, reads_issued - xfers);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc_q.push_back(cyc);
      end
      prev_hold = (fvalid === 1'b1) && (ready !== 1'b1);
      prev_beat = {flast, feature};
    end
  end

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    done_cyc_q.delete();
    rd_exp = 0;
    reads_issued = 0;
    xfers = 0;
    lasts = 0;
    done_cnt = 0;
    prev_hold = 1'b0;
  endtask

  task automatic load_frames(input int n);
    logic [7:0] px;
    for (int f = 0; f < n; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        px = 8'(i);
        exp_q.push_back({(i == FRAME - 1) ? 1'b1 : 1'b0, px});
      end
    end
  endtask

  task automatic start_frame(output int c0);
    start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0;
  endtask

  function automatic logic pick_ready(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 3 == 0);
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic run_until(input int target, input int mode, input int budget, input int start_at);
    int k;
    logic poked;
    k = 0;
    poked = 1'b0;
    while (done_cnt < target && k < budget) begin
      ready = pick_ready(mode, k);
      if (!poked && start_at >= 0 && xfers >= start_at) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      k++;
    end
    start = 1'b0;
    checks++;
    if (done_cnt < target) begin
      failures++;
      $display("FAIL timeout got done_cnt=%0d want %0d", done_cnt, target);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({busy, done, rd_en, fvalid, flast} !== 5'b0 || feature !== 8'd0 ||
        dbg_state !== feature_stream_pkg::IDLE) begin
      failures++;
      $display("FAIL %s got busy=%b done=%b rd_en=%b valid=%b last=%b data=%0d state=%0d want all 0",
               tag, busy, done, rd_en, fvalid, flast, feature, dbg_state);
    end
  endtask

  task automatic check_frame_end(input string tag, input int want_xfers, input int want_lasts);
    checks++;
    if (xfers != want_xfers || lasts != want_lasts || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s got xfers=%0d lasts=%0d left=%0d want xfers=%0d lasts=%0d left=0",
               tag, xfers, lasts, exp_q.size(), want_xfers, want_lasts);
    end
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_state");
    tick();
  endtask

  task automatic test_full_frame();
    int c0;
    logic want;
    clear_model();
    load_frames(1);
    ready = 1'b1;
    mon_en = 1'b1;
    start_frame(c0);
    for (int k = 1; k <= 1030; k++) begin
      @(negedge clk);
      want = (k <= 1026);
      checks++;
      if (busy !== want) begin
        failures++;
        $display("FAIL busy k=%0d got=%b want=%b", k, busy, want);
      end
      want = (k == 1027);
      checks++;
      if (done !== want) begin
        failures++;
        $display("FAIL done k=%0d got=%b want=%b", k, done, want);
      end
      if (k == 2 || k == 3) begin
        want = (k == 3);
        checks++;
        if (fvalid !== want) begin
          failures++;
          $display("FAIL first_valid k=%0d got=%b want=%b", k, fvalid, want);
        end
      end
      tick();
    end
    check_frame_end("full_frame", FRAME, 1);
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL full_done_count got=%0d want=1", done_cnt);
    end
  endtask

  task automatic test_throttled();
    int c0;
    clear_model();
    load_frames(1);
    ready = 1'b0;
    start_frame(c0);
    run_until(1, 1, 4000, -1);
    check_frame_end("throttled", FRAME, 1);
  endtask

  task automatic test_stall();
    int c0;
    clear_model();
    load_frames(1);
    ready = 1'b0;
    start_frame(c0);
    repeat (50) tick();
    @(negedge clk);
    checks++;
    if (reads_issued != 2 || fvalid !== 1'b1 || feature !== 8'd0 || flast !== 1'b0) begin
      failures++;
      $display("FAIL stall got reads=%0d valid=%b data=%0d last=%b want reads=2 valid=1 data=0 last=0",
               reads_issued, fvalid, feature, flast);
    end
    tick();
    run_until(1, 0, 1200, -1);
    check_frame_end("stall_release", FRAME, 1);
  endtask

  task automatic test_ignore_start();
    int c0;
    clear_model();
    load_frames(1);
    ready = 1'b1;
    start_frame(c0);
    run_until(1, 2, 5000, 500);
    repeat (5) tick();
    check_frame_end("ignore_start", FRAME, 1);
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start_done got done_cnt=%0d busy=%b want done_cnt=1 busy=0", done_cnt, busy);
    end
  endtask

  task automatic test_mid_reset();
    int c0;
    int k;
    clear_model();
    load_frames(1);
    start_frame(c0);
    k = 0;
    while (xfers < 300 && k < 2000) begin
      ready = pick_ready(2, k);
      tick();
      k++;
    end
    checks++;
    if (xfers < 300) begin
      failures++;
      $display("FAIL mid_reset_timeout got xfers=%0d want 300", xfers);
    end
    rst = 1'b1;
    mon_en = 1'b0;
    tick();
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    check_outputs_zero("mid_reset_state");
    tick();
    mon_en = 1'b1;
    load_frames(1);
    start_frame(c0);
    run_until(1, 2, 5000, -1);
    check_frame_end("after_reset", FRAME, 1);
  endtask

  task automatic test_back_to_back();
    int c0;
    int k;
    clear_model();
    load_frames(2);
    ready = 1'b1;
    start_frame(c0);
    k = 0;
    while (done_cnt < 2 && k < 2200) begin
      start = (done === 1'b1 && done_cnt == 0);
      tick();
      k++;
    end
    start = 1'b0;
    check_frame_end("back_to_back", 2 * FRAME, 2);
    checks++;
    if (done_cyc_q.size() != 2) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d want=2", done_cyc_q.size());
    end else if (done_cyc_q[0] - c0 + 1 != 1027 || done_cyc_q[1] - c0 + 1 != 2054) begin
      failures++;
      $display("FAIL b2b_done_cycles got=%0d,%0d want=1027,2054",
               done_cyc_q[0] - c0 + 1, done_cyc_q[1] - c0 + 1);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_throttled();
    test_stall();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got time limit want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
